// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: FSM state encoding,
// default round/expansion timing, key width and key-cache helper functions.
package aes_pkg;

    // Key and round-index widths
    localparam int AES_KEY_W = 128;
    localparam int AES_IDX_W = 4;

    // Default timing: AES-128 has 10 rounds, the key expander needs 11 cycles
    localparam int AES_NR_DEF       = 10;
    localparam int AES_KEXP_LAT_DEF = 11;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KEXP  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_ROUND = 3'd3,
        ST_FINAL = 3'd4,
        ST_OUT   = 3'd5
    } aes_state_e;

    // Even parity over a full key, stored next to the cached key so that a
    // corrupted cache entry is never trusted as a hit.
    function automatic logic key_parity(input logic [AES_KEY_W-1:0] key);
        return ^key;
    endfunction

    // A cached key is a hit only when the entry is valid, its parity still
    // checks out and it equals the requested key.
    function automatic logic key_hit(
        input logic                 valid,
        input logic                 par,
        input logic [AES_KEY_W-1:0] cached,
        input logic [AES_KEY_W-1:0] key
    );
        return valid && (par == key_parity(cached)) && (cached == key);
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Request / key-expander / round-datapath / result signals of the AES round
// controller. The slave modport is the controller's view, the master modport
// is the view of the block that issues requests and consumes control.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    // Request side
    logic                   in_valid;
    logic                   in_ready;
    logic [AES_KEY_W-1:0]   in_key;

    // Key expander control
    logic                   kexp_en;
    logic [AES_KEY_W-1:0]   kexp_key;

    // Round datapath control
    logic                   rnd_load;
    logic                   rnd_en;
    logic                   rnd_last;
    logic [AES_IDX_W-1:0]   rnd_idx;

    // Result side and status
    logic                   out_valid;
    logic                   out_ready;
    logic                   busy;

    modport slave (
        input  in_valid,
        input  in_key,
        input  out_ready,
        output in_ready,
        output kexp_en,
        output kexp_key,
        output rnd_load,
        output rnd_en,
        output rnd_last,
        output rnd_idx,
        output out_valid,
        output busy
    );

    modport master (
        output in_valid,
        output in_key,
        output out_ready,
        input  in_ready,
        input  kexp_en,
        input  kexp_key,
        input  rnd_load,
        input  rnd_en,
        input  rnd_last,
        input  rnd_idx,
        input  out_valid,
        input  busy
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// AES round controller. Accepts a key, runs the key expander unless the key
// matches the single-entry key cache, then sequences the round datapath
// through load, NR-1 full rounds and a final round, and holds the result
// valid until the consumer takes it.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR       = AES_NR_DEF,
    parameter int KEXP_LAT = AES_KEXP_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset_n,
    aes_round_ctrl_if.slave bus
);

    // Expansion down-counter: loaded with KEXP_LAT-1, KEXP ends when it hits 0
    localparam int CNT_W = (KEXP_LAT > 1) ? $clog2(KEXP_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(KEXP_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Round-index landmarks
    localparam logic [AES_IDX_W-1:0] IDX_ZERO   = {AES_IDX_W{1'b0}};
    localparam logic [AES_IDX_W-1:0] IDX_ONE    = AES_IDX_W'(1);
    localparam logic [AES_IDX_W-1:0] IDX_LAST   = AES_IDX_W'(NR);
    localparam logic [AES_IDX_W-1:0] IDX_PENULT = AES_IDX_W'(NR - 1);

    localparam logic [AES_KEY_W-1:0] KEY_ZERO = {AES_KEY_W{1'b0}};

    aes_state_e             state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [AES_KEY_W-1:0]   kexp_key_r;
    logic [AES_KEY_W-1:0]   cache_key_r;
    logic                   cache_par_r;
    logic                   cache_valid_r;

    logic                   kexp_en_r;
    logic                   rnd_load_r;
    logic                   rnd_en_r;
    logic                   rnd_last_r;
    logic [AES_IDX_W-1:0]   rnd_idx_r;
    logic                   out_valid_r;
    logic                   busy_r;

    logic                   in_ready_s;
    logic                   accept_s;
    logic                   cache_hit_s;

    // in_ready is gated by reset_n so it reads 0 throughout reset and 1 as
    // soon as reset is released while the FSM sits in IDLE.
    assign in_ready_s  = reset_n & (state_r == ST_IDLE);
    assign accept_s    = bus.in_valid & in_ready_s;
    assign cache_hit_s = key_hit(cache_valid_r, cache_par_r, cache_key_r, bus.in_key);

    // Request sequencing FSM with all control outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            cnt_r         <= CNT_ZERO;
            kexp_key_r    <= KEY_ZERO;
            cache_key_r   <= KEY_ZERO;
            cache_par_r   <= 1'b0;
            cache_valid_r <= 1'b0;
            kexp_en_r     <= 1'b0;
            rnd_load_r    <= 1'b0;
            rnd_en_r      <= 1'b0;
            rnd_last_r    <= 1'b0;
            rnd_idx_r     <= IDX_ZERO;
            out_valid_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        kexp_key_r <= bus.in_key;
                        busy_r     <= 1'b1;
                        if (cache_hit_s) begin
                            // Round keys already sit in key_reg: skip expansion
                            state_r    <= ST_LOAD;
                            rnd_load_r <= 1'b1;
                            rnd_idx_r  <= IDX_ZERO;
                        end else begin
                            state_r   <= ST_KEXP;
                            kexp_en_r <= 1'b1;
                            cnt_r     <= CNT_LOAD;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end

                ST_KEXP: begin
                    // Start pulse is only ever one cycle wide
                    kexp_en_r <= 1'b0;
                    if (cnt_r == CNT_ZERO) begin
                        // key_reg now holds this key's schedule
                        cache_valid_r <= 1'b1;
                        cache_key_r   <= kexp_key_r;
                        cache_par_r   <= key_parity(kexp_key_r);
                        state_r       <= ST_LOAD;
                        rnd_load_r    <= 1'b1;
                        rnd_idx_r     <= IDX_ZERO;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end

                ST_LOAD: begin
                    rnd_load_r <= 1'b0;
                    rnd_en_r   <= 1'b1;
                    if (IDX_LAST == IDX_ONE) begin
                        // Single-round cipher goes straight to the final round
                        state_r    <= ST_FINAL;
                        rnd_last_r <= 1'b1;
                        rnd_idx_r  <= IDX_LAST;
                    end else begin
                        state_r   <= ST_ROUND;
                        rnd_idx_r <= IDX_ONE;
                    end
                end

                ST_ROUND: begin
                    if (rnd_idx_r == IDX_PENULT) begin
                        state_r    <= ST_FINAL;
                        rnd_last_r <= 1'b1;
                        rnd_idx_r  <= IDX_LAST;
                    end else begin
                        rnd_idx_r <= rnd_idx_r + IDX_ONE;
                    end
                end

                ST_FINAL: begin
                    state_r     <= ST_OUT;
                    rnd_en_r    <= 1'b0;
                    rnd_last_r  <= 1'b0;
                    rnd_idx_r   <= IDX_ZERO;
                    out_valid_r <= 1'b1;
                end

                ST_OUT: begin
                    if (bus.out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end

                default: begin
                    // Illegal encoding: drop everything and return to IDLE
                    state_r     <= ST_IDLE;
                    cnt_r       <= CNT_ZERO;
                    kexp_en_r   <= 1'b0;
                    rnd_load_r  <= 1'b0;
                    rnd_en_r    <= 1'b0;
                    rnd_last_r  <= 1'b0;
                    rnd_idx_r   <= IDX_ZERO;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.kexp_en   = kexp_en_r;
    assign bus.kexp_key  = kexp_key_r;
    assign bus.rnd_load  = rnd_load_r;
    assign bus.rnd_en    = rnd_en_r;
    assign bus.rnd_last  = rnd_last_r;
    assign bus.rnd_idx   = rnd_idx_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: directed scenarios (reset, miss,
// hit, backpressure, reset mid-expansion, in_valid held while busy) followed
// by randomized traffic, all checked every cycle against a timeline model.
module tb_aes_round_ctrl;

    localparam int NR       = 10;
    localparam int KEXP_LAT = 11;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;

    logic clk = 1'b0;
    logic reset_n;

    aes_round_ctrl_if bus();

    aes_round_ctrl #(.NR(NR), .KEXP_LAT(KEXP_LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a request is a timeline measured in cycles since its
    // acceptance edge; the cache is one (valid, key) pair.
    bit           m_active = 1'b0;
    int           m_t      = 0;
    bit           m_miss   = 1'b0;
    bit           m_cv     = 1'b0;
    logic [127:0] m_ck     = 128'd0;
    logic [127:0] m_key    = 128'd0;

    int           kexp_pulses = 0;
    logic [3:0]   idx_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int m_base();
        return m_miss ? KEXP_LAT : 0;
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_cv     = 1'b0;
        m_ck     = 128'd0;
        m_key    = 128'd0;
    endtask

    // Advance the model across one rising edge using the inputs seen there
    task automatic model_edge();
        if (!reset_n) begin
            model_reset();
        end else if (!m_active) begin
            if (bus.in_valid) begin
                m_active = 1'b1;
                m_t      = 0;
                m_miss   = !(m_cv && (bus.in_key == m_ck));
                m_key    = bus.in_key;
            end
        end else if ((m_t > m_base() + NR) && bus.out_ready) begin
            m_active = 1'b0;
        end else begin
            m_t++;
            if (m_miss && (m_t == KEXP_LAT)) begin
                m_cv = 1'b1;
                m_ck = m_key;
            end
        end
    endtask

    task automatic check_outputs();
        int  b;
        bit  a;
        int  e_idx;
        b = m_base();
        a = m_active;
        e_idx = (a && (m_t >= b) && (m_t <= b + NR)) ? (m_t - b) : 0;
        chk("in_ready",  128'(bus.in_ready),  128'(reset_n && !a));
        chk("busy",      128'(bus.busy),      128'(a));
        chk("kexp_en",   128'(bus.kexp_en),   128'(a && m_miss && (m_t == 0)));
        chk("kexp_key",  bus.kexp_key,        m_key);
        chk("rnd_load",  128'(bus.rnd_load),  128'(a && (m_t == b)));
        chk("rnd_en",    128'(bus.rnd_en),    128'(a && (m_t > b) && (m_t <= b + NR)));
        chk("rnd_last",  128'(bus.rnd_last),  128'(a && (m_t == b + NR)));
        chk("rnd_idx",   128'(bus.rnd_idx),   128'(e_idx));
        chk("out_valid", 128'(bus.out_valid), 128'(a && (m_t > b + NR)));
    endtask

    // One clock: edge, model update, then check just after the edge
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
        if (bus.kexp_en) kexp_pulses++;
        if (bus.rnd_load || bus.rnd_en) idx_q.push_back(bus.rnd_idx);
    endtask

    task automatic send(input logic [127:0] key);
        bus.in_valid = 1'b1;
        bus.in_key   = key;
        kexp_pulses  = 0;
        idx_q.delete();
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!bus.out_valid && (lat < 200)) begin
            step();
            lat++;
        end
        if (!bus.out_valid) chk("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic finish_out();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("idle_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        step();
        step();
        #2;
        reset_n = 1'b1;
        #1;
        check_outputs();
        chk("rst_release_in_ready", 128'(bus.in_ready), 128'd1);
    endtask

    initial begin
        int           lat;
        int           n;
        logic [127:0] key_b;
        logic [127:0] pool [3];

        bus.in_valid  = 1'b0;
        bus.in_key    = 128'd0;
        bus.out_ready = 1'b0;
        reset_n       = 1'b1;
        #1;
        reset_n = 1'b0;
        model_reset();
        step();
        step();
        #2;
        reset_n = 1'b1;
        #1;
        check_outputs();
        chk("rst_release_in_ready", 128'(bus.in_ready), 128'd1);

        // Cache miss with the FIPS-197 key
        send(KEY_A);
        wait_out(lat);
        chk("miss_latency", 128'(lat), 128'(KEXP_LAT + NR + 1));
        chk("miss_kexp_pulses", 128'(kexp_pulses), 128'd1);
        chk("miss_idx_count", 128'(idx_q.size()), 128'(NR + 1));
        foreach (idx_q[i]) chk($sformatf("miss_idx_%0d", i), 128'(idx_q[i]), 128'(i));
        finish_out();

        // Cache hit with the same key, then 5 cycles of backpressure
        send(KEY_A);
        wait_out(lat);
        chk("hit_latency", 128'(lat), 128'(NR + 1));
        chk("hit_kexp_pulses", 128'(kexp_pulses), 128'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_valid", 128'(bus.out_valid), 128'd1);
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        finish_out();

        // Reset during the 4th KEXP cycle, then resubmit the same key
        key_b = {$urandom, $urandom, $urandom, $urandom};
        send(key_b);
        step();
        step();
        step();
        chk("kexp_phase", 128'(bus.busy && !bus.rnd_load && !bus.rnd_en), 128'd1);
        pulse_reset();
        send(key_b);
        wait_out(lat);
        chk("rst_resubmit_kexp", 128'(kexp_pulses), 128'd1);
        chk("rst_resubmit_latency", 128'(lat), 128'(KEXP_LAT + NR + 1));
        finish_out();

        // Reset while idle must drop the cached key
        pulse_reset();
        send(key_b);
        wait_out(lat);
        chk("rst_cache_clear_kexp", 128'(kexp_pulses), 128'd1);
        finish_out();

        // in_valid held from ROUND onward must wait for IDLE and then miss
        send(key_b);
        step();
        step();
        bus.in_valid  = 1'b1;
        bus.in_key    = KEY_C;
        bus.out_ready = 1'b1;
        n = 0;
        while (!bus.in_ready && (n < 100)) begin
            step();
            n++;
        end
        chk("held_reaches_idle", 128'(bus.in_ready), 128'd1);
        chk("held_kexp_key", bus.kexp_key, key_b);
        bus.out_ready = 1'b0;
        send(KEY_C);
        wait_out(lat);
        chk("held_miss_kexp", 128'(kexp_pulses), 128'd1);
        chk("held_miss_latency", 128'(lat), 128'(KEXP_LAT + NR + 1));
        finish_out();

        // Randomized traffic over a small key pool so hits and misses mix
        pool[0] = KEY_A;
        pool[1] = KEY_C;
        pool[2] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) == 0);
            bus.in_key    = ($urandom_range(0, 7) == 0) ?
                            {$urandom, $urandom, $urandom, $urandom} :
                            pool[$urandom_range(0, 2)];
            bus.out_ready = ($urandom_range(0, 1) == 1);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10: number of cipher rounds.
REQ-002 SHALL have parameter KEXP_LAT, default 11: cycles from kexp_en pulse until key_reg holds all round keys.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1: request present.
REQ-006 SHALL have port in_ready, output, 1: controller can accept a request.
REQ-007 SHALL have port in_key, input, 128: cipher key of the request.
REQ-008 SHALL have port kexp_en, output, 1: one-cycle start pulse to the key expander.
REQ-009 SHALL have port kexp_key, output, 128: registered key driven to the expander's initial_key.
REQ-010 SHALL have port rnd_load, output, 1: datapath loads input block and applies round key 0.
REQ-011 SHALL have port rnd_en, output, 1: datapath executes one round.
REQ-012 SHALL have port rnd_last, output, 1: current round omits MixColumns.
REQ-013 SHALL have port rnd_idx, output, 4: round-key index selected from key_reg.
REQ-014 SHALL have port out_valid, output, 1: datapath result valid.
REQ-015 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-016 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, KEXP, LOAD, ROUND, FINAL, OUT.
REQ-018 SHALL assert in_ready only in IDLE; acceptance is in_valid && in_ready at a rising edge.
REQ-019 On acceptance, SHALL register in_key into kexp_key and go to LOAD if the cache is valid and in_key equals the cached key, otherwise go to KEXP.
REQ-020 SHALL assert kexp_en for exactly the first KEXP cycle.
REQ-021 SHALL stay in KEXP for exactly KEXP_LAT cycles, counted by a down-counter, then go to LOAD.
REQ-022 SHALL set the cache to valid with the cached key equal to kexp_key when leaving KEXP.
REQ-023 LOAD SHALL last one cycle with rnd_load=1 and rnd_idx=0, then go to ROUND.
REQ-024 ROUND SHALL assert rnd_en with rnd_idx running 1..NR-1, one per cycle, then go to FINAL.
REQ-025 FINAL SHALL last one cycle with rnd_en=1, rnd_last=1 and rnd_idx=NR, then go to OUT.
REQ-026 OUT SHALL hold out_valid=1 until out_ready=1 at a rising edge, then go to IDLE; out_ready outside OUT SHALL be ignored.
REQ-027 Latency from the acceptance edge to the first out_valid cycle SHALL be KEXP_LAT+NR+1 cycles on a cache miss and NR+1 on a cache hit.
REQ-028 rnd_load, rnd_en, rnd_last and kexp_en SHALL be mutually consistent: rnd_load and rnd_en are never high together, and rnd_last is high only when rnd_en is high.
REQ-029 in_valid during any non-IDLE state SHALL not be accepted and SHALL not disturb the sequence.
REQ-030 rnd_idx SHALL be 0 in IDLE, KEXP and OUT.

Reset
REQ-031 reset_n low SHALL asynchronously force IDLE with all of the following cleared: kexp_en, rnd_load, rnd_en, rnd_last, out_valid and busy set to 0; rnd_idx, kexp_key and the counter set to 0; the cache marked invalid.
REQ-032 in_ready SHALL be 0 while reset_n is low and SHALL be 1 in the first cycle after release.
REQ-033 Reset asserted mid-operation, including mid-KEXP, SHALL abandon the request; the next request SHALL take the miss path.

Structure
REQ-034 SHALL place the state enum, NR, KEXP_LAT defaults and the 128-bit key width in shared package aes_pkg.
REQ-035 SHALL need no sub-module: the counter and the key-cache comparator are inline; the key expander and round datapath are instantiated by the parent.

Verification
REQ-036 Bench SHALL cover reset release: all outputs 0, in_ready=1 in the first cycle after reset_n rises.
REQ-037 Bench SHALL cover a cache miss: key 2b7e151628aed2a6abf7158809cf4f3c accepted -> one kexp_en pulse, 11 KEXP cycles, rnd_idx sequence 0..10, out_valid 22 cycles after acceptance.
REQ-038 Bench SHALL cover a cache hit: the same key again -> no kexp_en, out_valid 11 cycles after acceptance.
REQ-039 Bench SHALL cover backpressure: out_ready held 0 for 5 cycles -> out_valid stays 1 and in_ready stays 0, then IDLE one cycle after out_ready=1.
REQ-040 Bench SHALL cover reset mid-operation: reset_n pulsed low during KEXP cycle 4 -> IDLE, and a resubmission of the same key issues kexp_en again.
REQ-041 Bench SHALL cover in_valid held high during ROUND with key 000102030405060708090a0b0c0d0e0f -> not accepted until IDLE, then taken as a miss.
